// File: rtl/song_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | song_reader: walks a song in a registered ROM, issuing note/duration   |
// | pairs to the note player. Rev 1.0                                      |
// +----------------------------------------------------------------------+
module song_reader #(
  parameter int SONG_W = 2,
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic [SONG_W-1:0]          song,
  input  logic                       note_done,
  output logic [SONG_W+ADDR_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]    rom_data,
  output logic                       new_note,
  output logic [NOTE_W-1:0]          note,
  output logic [DUR_W-1:0]           duration,
  output logic                       song_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_MAX = '1;

  state_t              r_state;
  state_t              w_next;
  logic [SONG_W-1:0]   r_song;
  logic [ADDR_W-1:0]   r_addr;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_dur;
  logic                r_new_note;
  logic                r_song_done;

  logic                w_song_chg;
  logic                w_inc;
  logic                w_clr;
  logic                w_load;
  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;

  assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = rom_data[DUR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Song change outranks pause, which outranks note_done and the end check.
  always_comb begin
    w_next     = r_state;
    w_inc      = 1'b0;
    w_clr      = 1'b0;
    w_load     = 1'b0;
    w_song_chg = (song != r_song) && (r_state != S_END);
    if (w_song_chg) begin
      w_next = S_IDLE;
    end else if (!play && (r_state != S_IDLE) && (r_state != S_END)) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (play) w_next = S_FETCH;
        S_FETCH: w_next = S_LATCH;
        S_LATCH: begin
          if (w_rom_dur == '0) begin
            w_next = S_END;
            w_clr  = 1'b1;
          end else begin
            w_next = S_ISSUE;
            w_load = 1'b1;
          end
        end
        S_ISSUE: w_next = S_WAIT;
        S_WAIT: begin
          if (note_done) begin
            w_inc  = 1'b1;
            w_next = (r_addr == C_ADDR_MAX) ? S_END : S_FETCH;
          end
        end
        S_END:   if (!play) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_song      <= '0;
      r_addr      <= '0;
      r_note      <= '0;
      r_dur       <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      if (w_song_chg) begin
        r_song <= song;
        r_addr <= '0;
      end else if (w_inc) begin
        r_addr <= r_addr + C_ADDR_ONE;
      end else if (w_clr) begin
        r_addr <= '0;
      end
      if (w_load) begin
        r_note <= w_rom_note;
        r_dur  <= w_rom_dur;
      end
      r_new_note  <= (w_next == S_ISSUE);
      r_song_done <= (w_next == S_END) && (r_state != S_END);
    end
  end

  assign rom_addr  = {r_song, r_addr};
  assign new_note  = r_new_note;
  assign note      = r_note;
  assign duration  = r_dur;
  assign song_done = r_song_done;

endmodule
`default_nettype wire

// File: tb/tb_song_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_song_reader: randomized and directed bench with a timeline model.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_song_reader;

  localparam int AW = 7;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play = 1'b0;
  logic [1:0]    song = 2'd0;
  logic          note_done = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          new_note;
  logic [5:0]    note;
  logic [5:0]    duration;
  logic          song_done;

  song_reader #(.SONG_W(2), .ADDR_W(5), .NOTE_W(6), .DUR_W(6)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .new_note(new_note),
    .note(note), .duration(duration), .song_done(song_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int errors = 0;
  int checks = 0;
  int nn_cnt = 0;
  int sd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode plus a countdown to the next issue; cd 3..1 are the
  // cycles between starting a fetch and the note pulse, 0 is waiting.
  localparam int M_IDLE = 0, M_RUN = 1, M_ENDED = 2;
  int            m_mode = M_IDLE;
  int            m_cd = 0;
  logic [1:0]    m_song = 2'd0;
  logic [4:0]    m_idx = 5'd0;
  logic [5:0]    m_note = 6'd0;
  logic [5:0]    m_dur = 6'd0;
  logic          m_nn = 1'b0;
  logic          m_sd = 1'b0;
  logic [DW-1:0] m_entry;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_cd = 0; m_song = 2'd0; m_idx = 5'd0;
      m_note = 6'd0; m_dur = 6'd0; m_nn = 1'b0; m_sd = 1'b0;
    end else begin
      m_nn = 1'b0;
      m_sd = 1'b0;
      if (song != m_song && m_mode != M_ENDED) begin
        m_song = song; m_idx = 5'd0; m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (play) begin m_mode = M_RUN; m_cd = 3; end
      end else if (m_mode == M_ENDED) begin
        if (!play) m_mode = M_IDLE;
      end else if (!play) begin
        m_mode = M_IDLE;
      end else if (m_cd == 3) begin
        m_cd = 2;
      end else if (m_cd == 2) begin
        m_entry = rom[{m_song, m_idx}];
        if (m_entry[5:0] == 6'd0) begin
          m_mode = M_ENDED; m_sd = 1'b1; m_idx = 5'd0;
        end else begin
          m_note = m_entry[11:6]; m_dur = m_entry[5:0]; m_nn = 1'b1; m_cd = 1;
        end
      end else if (m_cd == 1) begin
        m_cd = 0;
      end else if (note_done) begin
        if (m_idx == 5'd31) begin
          m_idx = 5'd0; m_mode = M_ENDED; m_sd = 1'b1;
        end else begin
          m_idx = m_idx + 5'd1; m_cd = 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rom_addr", 32'(rom_addr), 32'({m_song, m_idx}));
    chk("new_note", 32'(new_note), 32'(m_nn));
    chk("note", 32'(note), 32'(m_note));
    chk("duration", 32'(duration), 32'(m_dur));
    chk("song_done", 32'(song_done), 32'(m_sd));
    if (reset && new_note) nn_cnt++;
    if (reset && song_done) sd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_done();
    note_done = 1'b1;
    tick(1);
    note_done = 1'b0;
  endtask

  task automatic wait_nn(input string name, input int maxc);
    logic found = 1'b0;
    for (int k = 0; k < maxc && !found; k++) begin
      @(negedge clk);
      if (new_note === 1'b1) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_sd(input string name, input int maxc);
    logic found = 1'b0;
    for (int k = 0; k < maxc && !found; k++) begin
      @(negedge clk);
      if (song_done === 1'b1) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  int nn_before;
  int sd_before;

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    rom[0] = {6'd5, 6'd10};
    rom[1] = {6'd7, 6'd3};
    rom[2] = {6'd33, 6'd0};
    for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 1), 6'((i % 7) + 1)};
    rom[64] = {6'd9, 6'd4};
    rom[65] = {6'd0, 6'd5};
    rom[66] = {6'd11, 6'd6};
    rom[67] = {6'd2, 6'd0};
    for (int i = 0; i < 32; i++)
      rom[96 + i] = {6'($urandom_range(0, 63)),
                     ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63))};

    #1 reset = 1'b0;
    #2;
    chk("rst_new_note", 32'(new_note), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_duration", 32'(duration), 32'd0);
    chk("rst_song_done", 32'(song_done), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    tick(2);
    reset = 1'b1;
    play = 1'b1;

    wait_nn("first_note_seen", 10);
    chk("n1_note", 32'(note), 32'd5);
    chk("n1_dur", 32'(duration), 32'd10);
    tick(1);
    pulse_done();
    wait_nn("second_note_seen", 6);
    chk("n2_note", 32'(note), 32'd7);
    chk("n2_dur", 32'(duration), 32'd3);
    tick(1);

    play = 1'b0;
    repeat (5) begin tick(1); chk("pause_addr", 32'(rom_addr), 32'd1); end
    play = 1'b1;
    wait_nn("resume_seen", 6);
    chk("resume_note", 32'(note), 32'd7);
    chk("resume_dur", 32'(duration), 32'd3);
    tick(1);

    nn_before = nn_cnt;
    pulse_done();
    wait_sd("end0_seen", 6);
    tick(6);
    chk("no_third_note", 32'(nn_cnt), 32'(nn_before));
    chk("end0_addr", 32'(rom_addr), 32'd0);
    play = 1'b0;
    tick(2);
    play = 1'b1;
    wait_nn("restart_seen", 6);
    chk("restart_note", 32'(note), 32'd5);
    chk("restart_dur", 32'(duration), 32'd10);
    tick(1);

    sd_before = sd_cnt;
    song = 2'd2;
    tick(1);
    chk("switch_addr", 32'(rom_addr), 32'd64);
    wait_nn("song2_seen", 8);
    chk("song2_note", 32'(note), 32'd9);
    chk("song2_dur", 32'(duration), 32'd4);
    chk("switch_no_done", 32'(sd_cnt), 32'(sd_before));
    tick(1);

    play = 1'b0;
    note_done = 1'b1;
    tick(1);
    note_done = 1'b0;
    tick(2);
    chk("coinc_addr", 32'(rom_addr), 32'd64);
    play = 1'b1;
    wait_nn("coinc_seen", 6);
    chk("coinc_note", 32'(note), 32'd9);
    tick(1);

    sd_before = sd_cnt;
    song = 2'd1;
    for (int i = 0; i < 32; i++) begin
      wait_nn("full_seen", 8);
      tick(1);
      pulse_done();
    end
    wait_sd("full_end_seen", 4);
    tick(1);
    chk("full_done_once", 32'(sd_cnt), 32'(sd_before + 1));
    chk("full_addr", 32'(rom_addr), 32'd32);

    play = 1'b0;
    tick(2);
    song = 2'd2;
    play = 1'b1;
    wait_nn("pre_reset_seen", 8);
    tick(1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_new_note", 32'(new_note), 32'd0);
    chk("arst_note", 32'(note), 32'd0);
    chk("arst_duration", 32'(duration), 32'd0);
    chk("arst_song_done", 32'(song_done), 32'd0);
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    play = 1'b0;
    tick(1);
    reset = 1'b1;
    nn_before = nn_cnt;
    repeat (3) begin pulse_done(); tick(1); end
    chk("stray_done_no_note", 32'(nn_cnt), 32'(nn_before));

    for (int c = 0; c < 500; c++) begin
      play = ($urandom_range(0, 9) != 0);
      note_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) song = 2'($urandom_range(0, 3));
      tick(1);
    end
    note_done = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
